camera_readout: RTL

Receive-side companion to `camera_controller` for the 2x2 pixel camera. It monitors the controller's sensor control lines (`NRE_1`, `NRE_2`, `ADC`, `expose`, `erase`) and measures each exposure window. During readout it captures the digitised pixel value on every `ADC` strobe, tags it with row and column, and buffers it. Captured pixels leave through a valid/ready stream for downstream image logic.

---
 rtl/camera_readout_if.sv | 35 +++
 rtl/camera_readout.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/camera_readout_if.sv
// Signal bundle between the camera sensor control lines / pixel stream and camera_readout.
// The master side drives the sensor lines and pix_ready; the slave side is the readout block.
interface camera_readout_if #(
  parameter int DATA_W = 8
);
  logic              NRE_1;
  logic              NRE_2;
  logic              ADC;
  logic              expose;
  logic              erase;
  logic [DATA_W-1:0] adc_data;
  logic              pix_ready;
  logic              err_clr;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              pix_row;
  logic              pix_col;
  logic              pix_last;
  logic              frame_done;
  logic [7:0]        exp_cycles;
  logic              err_protocol;
  logic              err_overflow;

  modport master (
    output NRE_1, NRE_2, ADC, expose, erase, adc_data, pix_ready, err_clr,
    input  pix_valid, pix_data, pix_row, pix_col, pix_last, frame_done,
           exp_cycles, err_protocol, err_overflow
  );

  modport slave (
    input  NRE_1, NRE_2, ADC, expose, erase, adc_data, pix_ready, err_clr,
    output pix_valid, pix_data, pix_row, pix_col, pix_last, frame_done,
           exp_cycles, err_protocol, err_overflow
  );
endinterface

// File: rtl/camera_readout.sv
// Monitors the 2x2 camera control lines, measures exposure length and captures the four
// readout samples (tagged row/col/last) into a small FIFO drained by a valid/ready stream.
module camera_readout #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic            clk,
  input  logic            rst,
  camera_readout_if.slave bus
);
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int PTR_W   = ADDR_W + 1;
  localparam int ENTRY_W = DATA_W + 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPOSE,
    S_READOUT
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic               r_adc_prev;
  logic               r_expose_prev;
  logic [7:0]         r_exp_cnt;
  logic [7:0]         r_exp_cycles;
  logic [1:0]         r_idx;
  logic               r_frame_done;
  logic               r_err_protocol;
  logic               r_err_overflow;
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;

  logic               w_adc_rise;
  logic               w_exp_rise;
  logic               w_strobe_ok;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_accept;
  logic               w_set_ovf;
  logic               w_set_proto;
  logic               w_load_cnt;
  logic               w_latch_exp;
  logic               w_idx_clr;
  logic               w_idx_inc;
  logic               w_frame_done_next;
  logic [ENTRY_W-1:0] w_entry;
  logic [ENTRY_W-1:0] w_head;

  assign w_adc_rise  = bus.ADC & ~r_adc_prev;
  assign w_exp_rise  = bus.expose & ~r_expose_prev;
  assign w_strobe_ok = bus.NRE_1 ^ bus.NRE_2;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                    (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign w_pop    = !w_empty && bus.pix_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_accept  = w_push && (!w_full || w_pop);
  assign w_set_ovf = w_push && w_full && !w_pop;

  assign w_entry = {bus.adc_data, ~bus.NRE_2, r_idx[0], (r_idx == 2'd3)};
  assign w_head  = r_mem[r_rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_load_cnt        = 1'b0;
    w_latch_exp       = 1'b0;
    w_idx_clr         = 1'b0;
    w_idx_inc         = 1'b0;
    w_push            = 1'b0;
    w_set_proto       = 1'b0;
    w_frame_done_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_exp_rise && !bus.erase) begin
          w_state_next = S_EXPOSE;
          w_load_cnt   = 1'b1;
        end
      end
      S_EXPOSE: begin
        if (bus.erase) begin
          w_state_next = S_IDLE;
          w_set_proto  = 1'b1;
        end else if (!bus.expose) begin
          w_state_next = S_READOUT;
          w_latch_exp  = 1'b1;
          w_idx_clr    = 1'b1;
        end
      end
      S_READOUT: begin
        if (w_exp_rise) begin
          // New exposure before the frame completed: abandon the partial frame.
          w_state_next = S_EXPOSE;
          w_set_proto  = 1'b1;
          w_load_cnt   = 1'b1;
          w_idx_clr    = 1'b1;
        end else if (w_adc_rise) begin
          if (w_strobe_ok) begin
            w_push    = 1'b1;
            w_idx_inc = 1'b1;
            if (r_idx == 2'd3) begin
              w_frame_done_next = 1'b1;
              w_state_next      = S_IDLE;
            end
          end else begin
            w_set_proto = 1'b1;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_adc_prev     <= 1'b0;
      r_expose_prev  <= 1'b0;
      r_exp_cnt      <= 8'd0;
      r_exp_cycles   <= 8'd0;
      r_idx          <= 2'd0;
      r_frame_done   <= 1'b0;
      r_err_protocol <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      r_adc_prev    <= bus.ADC;
      r_expose_prev <= bus.expose;
      r_frame_done  <= w_frame_done_next;

      if (w_load_cnt) begin
        r_exp_cnt <= 8'd1;
      end else if (r_state == S_EXPOSE && r_exp_cnt != 8'hFF) begin
        r_exp_cnt <= r_exp_cnt + 8'd1;
      end

      if (w_latch_exp) begin
        r_exp_cycles <= r_exp_cnt;
      end

      if (w_idx_clr) begin
        r_idx <= 2'd0;
      end else if (w_idx_inc) begin
        r_idx <= r_idx + 2'd1;
      end

      if (w_set_proto) begin
        r_err_protocol <= 1'b1;
      end else if (bus.err_clr) begin
        r_err_protocol <= 1'b0;
      end

      if (w_set_ovf) begin
        r_err_overflow <= 1'b1;
      end else if (bus.err_clr) begin
        r_err_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= w_entry;
    end
  end

  // Stream fields read as zero while empty so reset leaves every output at 0.
  assign bus.pix_valid    = !w_empty;
  assign bus.pix_data     = w_empty ? '0 : w_head[ENTRY_W-1:3];
  assign bus.pix_row      = !w_empty && w_head[2];
  assign bus.pix_col      = !w_empty && w_head[1];
  assign bus.pix_last     = !w_empty && w_head[0];
  assign bus.frame_done   = r_frame_done;
  assign bus.exp_cycles   = r_exp_cycles;
  assign bus.err_protocol = r_err_protocol;
  assign bus.err_overflow = r_err_overflow;
endmodule
